// File: rtl/ascon_pack.sv
// Shared types, round-count constants and round-constant helper for the
// Ascon permutation datapath and its sequencer.
package ascon_pack;

  // Word 0 is x0; each word is 64 bits with bit 0 as the LSB.
  typedef logic [4:0][63:0] type_state;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } seq_state_t;

  localparam int ROUNDS_A = 12;
  localparam int ROUNDS_B = 6;

  localparam logic [3:0] FIRST_ROUND_A = 4'd0;
  localparam logic [3:0] FIRST_ROUND_B = 4'(ROUNDS_A - ROUNDS_B);
  localparam logic [3:0] LAST_ROUND    = 4'(ROUNDS_A - 1);

  // 5-bit S-box, input/output column ordered {x0,x1,x2,x3,x4} with x0 as MSB.
  localparam logic [4:0] SBOX_TABLE [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  function automatic logic [7:0] round_constant(input logic [3:0] r);
    return {4'hf - r, r};
  endfunction

endpackage

// File: rtl/constant_addition.sv
// Round-constant addition: xors the round constant into the low byte of x2.
module constant_addition
  import ascon_pack::*;
(
  input  type_state  state,
  input  logic [3:0] round_idx,
  output type_state  result
);

  always_comb begin
    result = state;
    result[2][7:0] = state[2][7:0] ^ round_constant(round_idx);
  end

endmodule

// File: rtl/diffusion_layer.sv
// Linear diffusion layer: each word xored with two right-rotations of itself.
module diffusion_layer
  import ascon_pack::*;
(
  input  type_state state,
  output type_state result
);

  genvar gi;
  for (gi = 0; gi < 5; gi++) begin : g_word
    localparam int RA = ROT_A[gi];
    localparam int RB = ROT_B[gi];

    assign result[gi] = state[gi]
                      ^ {state[gi][RA-1:0], state[gi][63:RA]}
                      ^ {state[gi][RB-1:0], state[gi][63:RB]};
  end

endmodule

// File: rtl/permutation_round.sv
// One combinational Ascon round: constant addition, substitution, diffusion.
module permutation_round
  import ascon_pack::*;
(
  input  type_state  state,
  input  logic [3:0] round_idx,
  output type_state  result
);

  type_state after_const;
  type_state after_sbox;

  constant_addition u_const (
    .state     (state),
    .round_idx (round_idx),
    .result    (after_const)
  );

  substitution_layer u_sbox (
    .state  (after_const),
    .result (after_sbox)
  );

  diffusion_layer u_diff (
    .state  (after_sbox),
    .result (result)
  );

endmodule

// File: rtl/substitution_layer.sv
// Substitution layer: the 5-bit S-box applied to each of the 64 bit-columns.
module substitution_layer
  import ascon_pack::*;
(
  input  type_state state,
  output type_state result
);

  genvar gi;
  for (gi = 0; gi < 64; gi++) begin : g_col
    logic [4:0] col_in;
    logic [4:0] col_out;

    assign col_in  = {state[0][gi], state[1][gi], state[2][gi], state[3][gi], state[4][gi]};
    assign col_out = SBOX_TABLE[col_in];

    assign result[0][gi] = col_out[4];
    assign result[1][gi] = col_out[3];
    assign result[2][gi] = col_out[2];
    assign result[3][gi] = col_out[1];
    assign result[4][gi] = col_out[0];
  end

endmodule

// File: rtl/ascon_round_sequencer.sv
// Iterates one permutation_round per clock to compute p^a (12 rounds) or
// p^b (6 rounds), then holds the result until the consumer acknowledges it.
module ascon_round_sequencer
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       rounds_sel_i,
  input  type_state  state_i,
  input  logic       ack_i,
  output logic       busy_o,
  output logic       valid_o,
  output logic [3:0] round_o,
  output type_state  state_o
);

  seq_state_t fsm_reg;
  logic [3:0] round_reg;
  type_state  state_reg;
  type_state  round_next;

  permutation_round u_round (
    .state     (state_reg),
    .round_idx (round_reg),
    .result    (round_next)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm_reg   <= ST_IDLE;
      round_reg <= 4'd0;
      state_reg <= '0;
    end else begin
      case (fsm_reg)
        ST_IDLE: begin
          if (start_i) begin
            state_reg <= state_i;
            round_reg <= rounds_sel_i ? FIRST_ROUND_B : FIRST_ROUND_A;
            fsm_reg   <= ST_RUN;
          end
        end
        ST_RUN: begin
          state_reg <= round_next;
          // The counter parks at 0 after the last round instead of wrapping.
          if (round_reg == LAST_ROUND) begin
            round_reg <= 4'd0;
            fsm_reg   <= ST_DONE;
          end else begin
            round_reg <= round_reg + 4'd1;
          end
        end
        ST_DONE: begin
          if (ack_i) begin
            if (start_i) begin
              state_reg <= state_i;
              round_reg <= rounds_sel_i ? FIRST_ROUND_B : FIRST_ROUND_A;
              fsm_reg   <= ST_RUN;
            end else begin
              fsm_reg <= ST_IDLE;
            end
          end
        end
        default: begin
          fsm_reg   <= ST_IDLE;
          round_reg <= 4'd0;
        end
      endcase
    end
  end

  assign busy_o  = (fsm_reg == ST_RUN);
  assign valid_o = (fsm_reg == ST_DONE);
  assign round_o = (fsm_reg == ST_RUN) ? round_reg : 4'd0;
  assign state_o = state_reg;

endmodule

// File: tb/tb_ascon_round_sequencer.sv
// Directed bench for ascon_round_sequencer against an independent word-level
// Ascon permutation model.
module tb_ascon_round_sequencer;
  import ascon_pack::*;

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic       start_i;
  logic       rounds_sel_i;
  type_state  state_i;
  logic       ack_i;
  logic       busy_o;
  logic       valid_o;
  logic [3:0] round_o;
  type_state  state_o;

  int vectors_applied = 0;
  int miscompares     = 0;

  type_state vec_a, vec_b, vec_c;
  type_state exp_a, exp_b, exp_c, exp_d, exp_e;

  ascon_round_sequencer dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .rounds_sel_i (rounds_sel_i),
    .state_i      (state_i),
    .ack_i        (ack_i),
    .busy_o       (busy_o),
    .valid_o      (valid_o),
    .round_o      (round_o),
    .state_o      (state_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check_vec(input string tag, input logic [319:0] got, input logic [319:0] exp);
    vectors_applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Reference rounds written in the bit-sliced style of the C reference code.
  function automatic type_state ref_perm(input type_state s, input int first);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    for (int r = first; r < 12; r++) begin
      x2 = x2 ^ 64'(((15 - r) << 4) | r);
      x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
      x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
      x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
      x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
      x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
      x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
      x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    end
    return {x4, x3, x2, x1, x0};
  endfunction

  task automatic launch(input logic sel, input type_state st, input logic ack);
    start_i      = 1'b1;
    rounds_sel_i = sel;
    state_i      = st;
    ack_i        = ack;
    @(negedge clock_i);
    start_i = 1'b0;
    ack_i   = 1'b0;
  endtask

  // Called one half-cycle after the start edge; ends in DONE.
  task automatic expect_run(input string tag, input logic sel, input type_state st,
                            output type_state exp);
    int first;
    first = sel ? 6 : 0;
    exp = ref_perm(st, first);
    for (int r = first; r < 12; r++) begin
      check_vec({tag, "/round"}, 320'(round_o), 320'(r));
      check_vec({tag, "/busy"},  320'(busy_o),  320'(1));
      check_vec({tag, "/valid"}, 320'(valid_o), 320'(0));
      start_i = r[0];
      state_i = ~st;
      @(negedge clock_i);
    end
    start_i = 1'b0;
    check_vec({tag, "/done_valid"}, 320'(valid_o), 320'(1));
    check_vec({tag, "/done_busy"},  320'(busy_o),  320'(0));
    check_vec({tag, "/done_round"}, 320'(round_o), 320'(0));
    check_vec({tag, "/state"},      320'(state_o), 320'(exp));
    $display("txn %s sel=%0d result=%0h", tag, sel, state_o);
  endtask

  task automatic do_ack();
    ack_i = 1'b1;
    @(negedge clock_i);
    ack_i = 1'b0;
    check_vec("ack/valid", 320'(valid_o), 320'(0));
    check_vec("ack/busy",  320'(busy_o),  320'(0));
  endtask

  initial begin
    vec_a = {64'h08090a0b0c0d0e0f, 64'h0001020304050607,
             64'h08090a0b0c0d0e0f, 64'h0001020304050607, 64'h80400c0600000000};
    vec_b = {64'hfedcba9876543210, 64'h0f1e2d3c4b5a6978,
             64'hdeadbeefcafef00d, 64'h5555aaaa3333cccc, 64'h0123456789abcdef};
    vec_c = '0;

    reset_i = 1'b1; start_i = 1'b0; ack_i = 1'b0; rounds_sel_i = 1'b0; state_i = '0;
    repeat (3) @(negedge clock_i);
    check_vec("rst/busy",  320'(busy_o),  320'(0));
    check_vec("rst/valid", 320'(valid_o), 320'(0));
    check_vec("rst/round", 320'(round_o), 320'(0));
    check_vec("rst/state", 320'(state_o), 320'(0));
    reset_i = 1'b0;

    // ack while idle has no effect
    do_ack();

    launch(1'b0, vec_a, 1'b0);
    expect_run("pa", 1'b0, vec_a, exp_a);
    do_ack();

    launch(1'b1, vec_b, 1'b0);
    expect_run("pb", 1'b1, vec_b, exp_b);

    // Hold in DONE while start toggles; nothing may change.
    for (int i = 0; i < 20; i++) begin
      start_i      = i[0];
      rounds_sel_i = 1'b0;
      state_i      = vec_a;
      @(negedge clock_i);
      check_vec("hold/valid", 320'(valid_o), 320'(1));
      check_vec("hold/busy",  320'(busy_o),  320'(0));
      check_vec("hold/state", 320'(state_o), 320'(exp_b));
    end
    start_i = 1'b0;
    do_ack();
    @(negedge clock_i);
    check_vec("noqueue/busy", 320'(busy_o), 320'(0));

    // Back-to-back: ack and start on the same edge.
    launch(1'b0, vec_c, 1'b0);
    expect_run("pa_zero", 1'b0, vec_c, exp_c);
    launch(1'b1, vec_a, 1'b1);
    expect_run("b2b", 1'b1, vec_a, exp_d);
    do_ack();

    // Reset mid-run at round 5, with start and ack also high.
    launch(1'b0, vec_b, 1'b0);
    repeat (5) @(negedge clock_i);
    check_vec("abort/round5", 320'(round_o), 320'(5));
    reset_i = 1'b1; start_i = 1'b1; ack_i = 1'b1;
    @(negedge clock_i);
    reset_i = 1'b0; start_i = 1'b0; ack_i = 1'b0;
    check_vec("abort/busy",  320'(busy_o),  320'(0));
    check_vec("abort/valid", 320'(valid_o), 320'(0));
    check_vec("abort/round", 320'(round_o), 320'(0));
    check_vec("abort/state", 320'(state_o), 320'(0));
    repeat (15) @(negedge clock_i);
    check_vec("abort/no_valid", 320'(valid_o), 320'(0));
    check_vec("abort/idle",     320'(busy_o),  320'(0));

    launch(1'b0, vec_b, 1'b0);
    expect_run("post_rst", 1'b0, vec_b, exp_e);
    do_ack();

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
